// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the convolution datapath: the job FSM state
// encoding and the default data/address widths. The convolution core and
// the same-window writer both import this package so that their state
// encodings and default widths stay in step.
//
// Contents:
//   DATA_W_DEF    default sample width in bits
//   ADDR_W_DEF    default index / size / memory address width in bits
//   conv_state_e  job FSM states: ST_IDLE, ST_RUN, ST_DONE
// -----------------------------------------------------------------------------
package conv_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } conv_state_e;

endpackage : conv_pkg

// File: rtl/same_win_chk.sv
// -----------------------------------------------------------------------------
// same_win_chk
// Combinational window test for "same"-mode cropping. A full-convolution
// index k is kept when init_same <= k < init_same + n. For kept samples the
// output-memory address is k - init_same.
//
// Ports:
//   k          in   ADDR_W+1  current full-convolution index
//   init_same  in   ADDR_W    first full-convolution index to keep
//   n          in   ADDR_W    length of signal X (= number of kept samples)
//   in_win     out  1         k lies inside the kept window
//   addr       out  ADDR_W    write address k - init_same (valid when in_win)
// -----------------------------------------------------------------------------
module same_win_chk
   import conv_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W:0]   k,
   input  logic [ADDR_W-1:0] init_same,
   input  logic [ADDR_W-1:0] n,
   output logic              in_win,
   output logic [ADDR_W-1:0] addr
);

   logic [ADDR_W:0] offset;
   logic            at_or_after;

   // NOTE: every output of an always_comb block is assigned on every path
   // (defaults first where there are branches); a missed path infers a latch.
   always_comb begin
      at_or_after = (k >= {1'b0, init_same});
      // Only meaningful when at_or_after; the wrapped value is never used.
      offset      = k - {1'b0, init_same};
      // Comparing the offset against n (rather than k against init_same + n)
      // bounds the address by n directly, so an inconsistent init_same can
      // never yield an address >= n.
      in_win      = at_or_after && (offset < {1'b0, n});
      addr        = offset[ADDR_W-1:0];
   end

endmodule : same_win_chk

// File: rtl/same_win_wr.sv
// -----------------------------------------------------------------------------
// same_win_wr
// Crops a stream of full-convolution samples (indices 0 .. N+M-2) down to the
// "same"-mode window of N samples starting at index init_same, and writes the
// kept samples to an output memory at addresses 0 .. N-1, one cycle after
// each accepted sample.
//
// FSM: IDLE -> RUN -> DONE -> IDLE. A start with N=0 or M=0 goes straight to
// DONE without writing anything. done_o pulses for the single DONE cycle.
//
// Ports:
//   clk_i        in   1        clock, rising edge
//   rstn_i       in   1        synchronous active-low reset
//   start_i      in   1        begin a job (honoured in IDLE only)
//   size_x_i     in   ADDR_W   N, length of signal X
//   size_y_i     in   ADDR_W   M, length of kernel Y
//   init_same_i  in   ADDR_W   first full-convolution index kept
//   res_valid_i  in   1        full-convolution sample available
//   res_data_i   in   DATA_W   full-convolution sample, index order
//   res_ready_o  out  1        sample accepted this cycle (RUN only)
//   mem_we_o     out  1        output-memory write strobe
//   mem_addr_o   out  ADDR_W   output-memory write address (held when idle)
//   mem_data_o   out  DATA_W   output-memory write data (held when idle)
//   wr_cnt_o     out  ADDR_W+1 writes in current job (SAME_WIN_WR_CNT_EN only)
//   busy_o       out  1        job in progress (RUN or DONE)
//   done_o       out  1        one-cycle completion pulse
//
// Build option: define SAME_WIN_WR_CNT_EN to add the wr_cnt_o write counter.
// -----------------------------------------------------------------------------
module same_win_wr
   import conv_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] size_x_i,
   input  logic [ADDR_W-1:0] size_y_i,
   input  logic [ADDR_W-1:0] init_same_i,
   input  logic              res_valid_i,
   input  logic [DATA_W-1:0] res_data_i,
   output logic              res_ready_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_data_o,
`ifdef SAME_WIN_WR_CNT_EN
   output logic [ADDR_W:0]   wr_cnt_o,
`endif
   output logic              busy_o,
   output logic              done_o
);

   // ---------------------------------------------------------------------------
   // Declarations
   // ---------------------------------------------------------------------------
   conv_state_e       state_q;
   conv_state_e       state_d;

   logic [ADDR_W-1:0] n_q;          // latched N
   logic [ADDR_W-1:0] m_q;          // latched M
   logic [ADDR_W-1:0] init_q;       // latched init_same
   logic [ADDR_W:0]   k_q;          // full-convolution index of the next beat

   logic [ADDR_W:0]   full_len;     // L = N + M - 1, one extra bit so it cannot wrap
   logic              start_acc;    // start honoured this cycle
   logic              empty_job;    // requested job has N=0 or M=0
   logic              beat;         // sample transferred this cycle
   logic              last_beat;    // beat carrying index L-1
   logic              in_win;
   logic [ADDR_W-1:0] win_addr;
   logic              wr_fire;      // beat that produces a memory write

   // ---------------------------------------------------------------------------
   // Beat and window decode
   // ---------------------------------------------------------------------------
   always_comb begin
      // Only used in RUN, where N and M are both non-zero, so L >= 1.
      full_len  = {1'b0, n_q} + {1'b0, m_q} - {{ADDR_W{1'b0}}, 1'b1};
      start_acc = (state_q == ST_IDLE) && start_i;
      empty_job = (size_x_i == '0) || (size_y_i == '0);
      beat      = res_valid_i && res_ready_o;
      last_beat = beat && (k_q == full_len - {{ADDR_W{1'b0}}, 1'b1});
      wr_fire   = beat && in_win;
   end

   same_win_chk #(
      .ADDR_W    (ADDR_W)
   ) u_win_chk (
      .k         (k_q),
      .init_same (init_q),
      .n         (n_q),
      .in_win    (in_win),
      .addr      (win_addr)
   );

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking (<=) assignments so every register
   // samples pre-edge values; blocking assignments here would create order-
   // dependent simulation and mismatch the synthesised flops.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and Moore outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      res_ready_o = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = empty_job ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            res_ready_o = 1'b1;
            busy_o      = 1'b1;
            if (last_beat) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            busy_o  = 1'b1;
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Job parameters and index counter
   // ---------------------------------------------------------------------------
   // start_i outside IDLE is ignored because start_acc is qualified by IDLE.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         n_q    <= '0;
         m_q    <= '0;
         init_q <= '0;
         k_q    <= '0;
      end else if (start_acc) begin
         n_q    <= size_x_i;
         m_q    <= size_y_i;
         init_q <= init_same_i;
         k_q    <= '0;
      end else if (beat) begin
         k_q    <= k_q + {{ADDR_W{1'b0}}, 1'b1};
      end
   end

   // ---------------------------------------------------------------------------
   // Output-memory write port (one cycle after the accepted beat)
   // ---------------------------------------------------------------------------
   // Address and data only load on a write, so they hold their last values
   // while the strobe is low.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         mem_we_o   <= 1'b0;
         mem_addr_o <= '0;
         mem_data_o <= '0;
      end else begin
         mem_we_o <= wr_fire;
         if (wr_fire) begin
            mem_addr_o <= win_addr;
            mem_data_o <= res_data_i;
         end
      end
   end

`ifdef SAME_WIN_WR_CNT_EN
   // ---------------------------------------------------------------------------
   // Write counter: cleared when a job starts, counts writes, holds afterwards
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         wr_cnt_o <= '0;
      end else if (start_acc) begin
         wr_cnt_o <= '0;
      end else if (wr_fire) begin
         wr_cnt_o <= wr_cnt_o + {{ADDR_W{1'b0}}, 1'b1};
      end
   end
`endif

endmodule : same_win_wr

// File: tb/tb_same_win_wr.sv
// -----------------------------------------------------------------------------
// tb_same_win_wr
// Directed, table-driven bench for same_win_wr. Each job record gives the
// sizes, window start, sample base value, stimulus variant and the slice of
// the expected-write table it must produce. A negedge monitor collects writes
// and done pulses; each job is then compared against its expected slice.
// -----------------------------------------------------------------------------
module tb_same_win_wr;

   localparam int DW = 32;
   localparam int AW = 6;

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic          start_i;
   logic [AW-1:0] size_x_i;
   logic [AW-1:0] size_y_i;
   logic [AW-1:0] init_same_i;
   logic          res_valid_i;
   logic [DW-1:0] res_data_i;
   logic          res_ready_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_data_o;
`ifdef SAME_WIN_WR_CNT_EN
   logic [AW:0]   wr_cnt_o;
`endif
   logic          busy_o;
   logic          done_o;

   same_win_wr #(
      .DATA_W      (DW),
      .ADDR_W      (AW)
   ) dut (
      .clk_i       (clk_i),
      .rstn_i      (rstn_i),
      .start_i     (start_i),
      .size_x_i    (size_x_i),
      .size_y_i    (size_y_i),
      .init_same_i (init_same_i),
      .res_valid_i (res_valid_i),
      .res_data_i  (res_data_i),
      .res_ready_o (res_ready_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_data_o  (mem_data_o),
`ifdef SAME_WIN_WR_CNT_EN
      .wr_cnt_o    (wr_cnt_o),
`endif
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   // ---------------------------------------------------------------------------
   // Bookkeeping
   // ---------------------------------------------------------------------------
   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   typedef struct {
      int addr;
      int data;
   } wr_t;

   typedef struct {
      int n;
      int m;
      int init;
      int base;
      bit toggle;     // res_valid_i alternates 1,0,1,0...
      bit mid_start;  // pulse start_i during RUN
      bit rst_mid;    // reset after 3 beats
      int first_wr;   // first entry in exp_wr
      int nwr;        // number of expected writes
   } job_t;

   wr_t  got_q[$];
   int   done_cnt;

   // Monitor: sample outputs away from the active edge.
   always @(negedge clk_i) begin
      if (mem_we_o) got_q.push_back('{int'(mem_addr_o), int'(mem_data_o)});
      if (done_o) done_cnt++;
   end

   // ---------------------------------------------------------------------------
   // Expected writes and job table (hand-computed)
   // ---------------------------------------------------------------------------
   wr_t  exp_wr [11];
   job_t jobs   [10];

   initial begin
      // N=5 M=3 init=1 samples 10..16: indices 1..5 kept
      exp_wr[0]  = '{0, 11}; exp_wr[1] = '{1, 12}; exp_wr[2] = '{2, 13};
      exp_wr[3]  = '{3, 14}; exp_wr[4] = '{4, 15};
      // N=4 M=1 init=0 samples 7..10
      exp_wr[5]  = '{0, 7};  exp_wr[6] = '{1, 8};  exp_wr[7] = '{2, 9};
      exp_wr[8]  = '{3, 10};
      // N=3 M=2 init=2 samples 20..23: indices 2,3 kept (window 2..4, L=4)
      exp_wr[9]  = '{0, 22}; exp_wr[10] = '{1, 23};

      //          n  m  init base tog mid rst first nwr
      jobs[0] = '{5, 3, 1,   10,  0,  0,  0,  0,    5};  // basic same window
      jobs[1] = '{4, 1, 0,   7,   0,  0,  0,  5,    4};  // M=1, all kept
      jobs[2] = '{0, 3, 0,   0,   0,  0,  0,  0,    0};  // N=0: immediate done
      jobs[3] = '{5, 3, 1,   10,  1,  0,  0,  0,    5};  // valid toggling
      jobs[4] = '{5, 3, 1,   10,  0,  1,  0,  0,    5};  // start during RUN ignored
      jobs[5] = '{5, 3, 1,   10,  0,  0,  1,  0,    2};  // reset after 3 beats
      jobs[6] = '{5, 3, 1,   10,  0,  0,  0,  0,    5};  // clean rerun after reset
      jobs[7] = '{3, 2, 2,   20,  0,  0,  0,  9,    2};  // window cut by end of stream
      jobs[8] = '{2, 2, 4,   30,  0,  0,  0,  0,    0};  // window beyond stream: no writes
      jobs[9] = '{3, 0, 0,   0,   0,  0,  0,  0,    0};  // M=0: immediate done
   end

   // ---------------------------------------------------------------------------
   // Job driver
   // ---------------------------------------------------------------------------
   task automatic run_job(input job_t j, input int idx);
      int  len;
      int  i;
      int  cyc;
      bit  beat;
      bit  valid;
      bit  stopped;
      string tag;

      tag      = $sformatf("job%0d", idx);
      got_q.delete();
      done_cnt = 0;
      len      = (j.n == 0 || j.m == 0) ? 0 : j.n + j.m - 1;

      @(negedge clk_i);
      size_x_i    = AW'(j.n);
      size_y_i    = AW'(j.m);
      init_same_i = AW'(j.init);
      start_i     = 1'b1;
      @(negedge clk_i);
      start_i     = 1'b0;
      if (len == 0) begin
         check({tag, "_empty_done_now"}, done_o, 1'b1);
      end else begin
         check({tag, "_run_ready"}, res_ready_o, 1'b1);
      end

      i       = 0;
      cyc     = 0;
      stopped = 0;
      while (i < len && cyc < 200 && !stopped) begin
         valid       = !(j.toggle && (cyc % 2 == 1));
         res_valid_i = valid;
         res_data_i  = valid ? DW'(j.base + i) : 32'hdead_beef;
         if (j.mid_start && i == 2) begin
            size_x_i    = AW'(1);
            size_y_i    = AW'(1);
            init_same_i = AW'(0);
            start_i     = 1'b1;
         end else begin
            start_i     = 1'b0;
         end
         beat = valid && res_ready_o;
         @(negedge clk_i);
         cyc++;
         if (beat) i++;
         if (j.rst_mid && i == 3) begin
            res_valid_i = 1'b0;
            rstn_i      = 1'b0;
            @(negedge clk_i);
            rstn_i      = 1'b1;
            check({tag, "_rst_we"},    mem_we_o,    1'b0);
            check({tag, "_rst_addr"},  mem_addr_o,  '0);
            check({tag, "_rst_data"},  mem_data_o,  '0);
            check({tag, "_rst_busy"},  busy_o,      1'b0);
            check({tag, "_rst_ready"}, res_ready_o, 1'b0);
            check({tag, "_rst_done"},  done_o,      1'b0);
`ifdef SAME_WIN_WR_CNT_EN
            check({tag, "_rst_wr_cnt"}, wr_cnt_o,   '0);
`endif
            stopped = 1;
         end
      end
      res_valid_i = 1'b0;
      start_i     = 1'b0;
      check({tag, "_beat_budget"}, (cyc < 200), 1'b1);

      repeat (4) @(negedge clk_i);
      check({tag, "_done_pulses"}, done_cnt, stopped ? 0 : 1);
      check({tag, "_idle_busy"}, busy_o, 1'b0);
      check({tag, "_n_writes"}, got_q.size(), j.nwr);
      for (int w = 0; w < j.nwr && w < got_q.size(); w++) begin
         check($sformatf("%s_wr%0d_addr", tag, w), got_q[w].addr, exp_wr[j.first_wr + w].addr);
         check($sformatf("%s_wr%0d_data", tag, w), got_q[w].data, exp_wr[j.first_wr + w].data);
      end
      if (!stopped && j.nwr > 0) begin
         // Strobe low: address and data hold the last write.
         check({tag, "_hold_addr"}, mem_addr_o, AW'(exp_wr[j.first_wr + j.nwr - 1].addr));
         check({tag, "_hold_data"}, mem_data_o, DW'(exp_wr[j.first_wr + j.nwr - 1].data));
      end
`ifdef SAME_WIN_WR_CNT_EN
      if (!stopped) check({tag, "_wr_cnt"}, wr_cnt_o, j.nwr);
`endif
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   initial begin
      rstn_i      = 1'b0;
      start_i     = 1'b0;
      size_x_i    = '0;
      size_y_i    = '0;
      init_same_i = '0;
      res_valid_i = 1'b0;
      res_data_i  = '0;
      done_cnt    = 0;

      repeat (3) @(negedge clk_i);
      check("reset_ready", res_ready_o, 1'b0);
      check("reset_we",    mem_we_o,    1'b0);
      check("reset_addr",  mem_addr_o,  '0);
      check("reset_data",  mem_data_o,  '0);
      check("reset_busy",  busy_o,      1'b0);
      check("reset_done",  done_o,      1'b0);
`ifdef SAME_WIN_WR_CNT_EN
      check("reset_wr_cnt", wr_cnt_o,   '0);
`endif
      rstn_i = 1'b1;
      @(negedge clk_i);

      for (int t = 0; t < 10; t++) begin
         run_job(jobs[t], t);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog timeout got=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule : tb_same_win_wr
